kd_tree_ctrl: RTL and testbench

- Upstream sequencer for the kd_tree node array; drives the root node's top-side command/data port.
- Runs the full session: tree reset, center fill, sort, then one point query per pixel.
- Accepts centers and pixels on valid/ready streams.
- Returns each pixel's best center on a valid/ready result stream.

---
 rtl/kd_tree_pkg.sv | 38 +++
 rtl/kd_tree_ctrl_if.sv | 40 ++++
 rtl/kd_ctrl_watchdog.sv | 39 +++
 rtl/kd_tree_ctrl.sv | 134 +++++++++++++
 tb/tb_kd_tree_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg: command codes, widths and controller state shared by kd_tree_ctrl and node
// Contents: CMD_* command codes, PT_W (one point) and DATA_W (root data bus) widths,
//           ctrl_state_t controller states, pad_point() to place a point on the root bus.
package kd_tree_pkg;
    localparam int DIM_SIZE = 8;
    localparam int DIM      = 3;
    localparam int CMD_SIZE = 5;
    localparam int PT_W     = DIM * DIM_SIZE;
    localparam int DATA_W   = 2 * PT_W;

    typedef logic [CMD_SIZE-1:0] cmd_t;

    localparam cmd_t CMD_NOP              = 5'h00;
    localparam cmd_t CMD_RST              = 5'h1F;
    localparam cmd_t CMD_RST_DONE         = 5'h1E;
    localparam cmd_t CMD_CENTER_FILL      = 5'h01;
    localparam cmd_t CMD_CENTER_FILL_DONE = 5'h05;
    localparam cmd_t CMD_START_SORTING    = 5'h14;
    localparam cmd_t CMD_SORT_DONE        = 5'h15;
    localparam cmd_t CMD_POINT_IN         = 5'h16;
    localparam cmd_t CMD_RETURN_BEST      = 5'h18;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST,
        S_FILL,
        S_SORT,
        S_SORT_WAIT,
        S_PT_ISSUE,
        S_PT_WAIT,
        S_RESULT,
        S_DONE
    } ctrl_state_t;

    function automatic logic [DATA_W-1:0] pad_point(input logic [PT_W-1:0] p);
        return {{PT_W{1'b0}}, p};
    endfunction
endpackage

// File: rtl/kd_tree_ctrl_if.sv
// kd_tree_ctrl_if: streams and root port between the kd_tree controller and its surroundings
// Signals: start; center_valid/data/ready; pix_valid/data/last/ready;
//          res_valid/best/pix/ready; cmd/data to and from the root node; busy; done.
// Modports: master = controller side, slave = environment (sources, sink, root node).
interface kd_tree_ctrl_if;
    import kd_tree_pkg::*;

    logic              start;
    logic              center_valid;
    logic [PT_W-1:0]   center_data;
    logic              center_ready;
    logic              pix_valid;
    logic [PT_W-1:0]   pix_data;
    logic              pix_last;
    logic              pix_ready;
    logic              res_valid;
    logic [PT_W-1:0]   res_best;
    logic [PT_W-1:0]   res_pix;
    logic              res_ready;
    cmd_t              cmd_to_root;
    logic [DATA_W-1:0] data_to_root;
    cmd_t              cmd_from_root;
    logic [DATA_W-1:0] data_from_root;
    logic              busy;
    logic              done;

    modport master (
        input  start, center_valid, center_data, pix_valid, pix_data, pix_last, res_ready,
               cmd_from_root, data_from_root,
        output center_ready, pix_ready, res_valid, res_best, res_pix, cmd_to_root,
               data_to_root, busy, done
    );

    modport slave (
        output start, center_valid, center_data, pix_valid, pix_data, pix_last, res_ready,
               cmd_from_root, data_from_root,
        input  center_ready, pix_ready, res_valid, res_best, res_pix, cmd_to_root,
               data_to_root, busy, done
    );
endinterface

// File: rtl/kd_ctrl_watchdog.sv
// kd_ctrl_watchdog: wait-cycle counter that flags a stalled controller state
// Ports: clk, reset (sync, active-high); state = controller state, kick = restart the
//        count without a state change, en = state is one that waits on the tree;
//        expire = this is the LIMIT-th consecutive counted cycle.
// Only built with KD_TREE_CTRL_TIMEOUT_EN defined.
`ifdef KD_TREE_CTRL_TIMEOUT_EN
module kd_ctrl_watchdog
    import kd_tree_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  ctrl_state_t state,
    input  logic        kick,
    input  logic        en,
    output logic        expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;
    logic [W-1:0] eff;
    ctrl_state_t  prev;

    // The first cycle of a new state (or a kicked cycle) counts as cycle zero.
    assign eff    = (state != prev || kick) ? '0 : cnt;
    assign expire = en && eff == W'(LIMIT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            prev <= S_IDLE;
        end else begin
            prev <= state;
            cnt  <= en ? eff + 1'b1 : '0;
        end
    end
endmodule
`endif

// File: rtl/kd_tree_ctrl.sv
// kd_tree_ctrl: session sequencer driving the kd_tree root node (reset, fill, sort, queries)
// Ports: clk, reset (sync, active-high); bus (kd_tree_ctrl_if.master) carrying start,
//        center/pixel input streams, result stream, root command/data port, busy, done;
//        error (sticky timeout flag, only with KD_TREE_CTRL_TIMEOUT_EN defined).
// Optional feature macro: KD_TREE_CTRL_TIMEOUT_EN adds a watchdog of TIMEOUT_CYCLES.
module kd_tree_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    kd_tree_ctrl_if.master bus
`ifdef KD_TREE_CTRL_TIMEOUT_EN
    ,
    output logic error
`endif
);
    import kd_tree_pkg::*;

    ctrl_state_t       state;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] data_q;
    logic              res_valid_q;
    logic [PT_W-1:0]   res_best_q;
    logic [PT_W-1:0]   res_pix_q;
    logic [PT_W-1:0]   pix_q;
    logic              last_q;
    logic              center_acc;
    logic              pix_acc;
    logic              expire;
    logic              unused_root_hi;

    // A center offered in the cycle the tree reports full is left on the stream.
    assign bus.center_ready = state == S_FILL && bus.cmd_from_root != CMD_CENTER_FILL_DONE;
    assign bus.pix_ready    = state == S_PT_ISSUE;
    assign bus.busy         = state != S_IDLE && state != S_DONE;
    assign bus.done         = state == S_DONE;
    assign bus.cmd_to_root  = cmd_q;
    assign bus.data_to_root = data_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_best     = res_best_q;
    assign bus.res_pix      = res_pix_q;

    assign center_acc     = bus.center_valid && bus.center_ready;
    assign pix_acc        = bus.pix_valid && bus.pix_ready;
    assign unused_root_hi = |bus.data_from_root[DATA_W-1:PT_W];

`ifdef KD_TREE_CTRL_TIMEOUT_EN
    logic wd_en;

    assign wd_en = state inside {S_RST, S_FILL, S_SORT_WAIT, S_PT_WAIT};

    kd_ctrl_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .state  (state),
        .kick   (center_acc),
        .en     (wd_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) error <= 1'b0;
        else if (expire) error <= 1'b1;
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_q       <= CMD_NOP;
            data_q      <= '0;
            res_valid_q <= 1'b0;
            res_best_q  <= '0;
            res_pix_q   <= '0;
            pix_q       <= '0;
            last_q      <= 1'b0;
        end else if (expire) begin
            state  <= S_DONE;
            cmd_q  <= CMD_NOP;
            data_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state  <= S_RST;
                    cmd_q  <= CMD_RST;
                    data_q <= '0;
                end
                S_RST: if (bus.cmd_from_root == CMD_RST_DONE) begin
                    state <= S_FILL;
                    cmd_q <= CMD_NOP;
                end
                S_FILL: if (bus.cmd_from_root == CMD_CENTER_FILL_DONE) begin
                    state  <= S_SORT;
                    cmd_q  <= CMD_START_SORTING;
                    data_q <= '0;
                end else begin
                    cmd_q  <= center_acc ? CMD_CENTER_FILL : CMD_NOP;
                    data_q <= center_acc ? pad_point(bus.center_data) : '0;
                end
                S_SORT: begin
                    state <= S_SORT_WAIT;
                    cmd_q <= CMD_NOP;
                end
                S_SORT_WAIT: if (bus.cmd_from_root == CMD_SORT_DONE) state <= S_PT_ISSUE;
                S_PT_ISSUE: if (pix_acc) begin
                    state  <= S_PT_WAIT;
                    pix_q  <= bus.pix_data;
                    last_q <= bus.pix_last;
                    cmd_q  <= CMD_POINT_IN;
                    data_q <= pad_point(bus.pix_data);
                end
                S_PT_WAIT: if (bus.cmd_from_root == CMD_RETURN_BEST) begin
                    state       <= S_RESULT;
                    res_best_q  <= bus.data_from_root[PT_W-1:0];
                    res_pix_q   <= pix_q;
                    res_valid_q <= 1'b1;
                    cmd_q       <= CMD_NOP;
                    data_q      <= '0;
                end
                S_RESULT: if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                    state       <= last_q ? S_DONE : S_PT_ISSUE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kd_tree_ctrl.sv
// tb_kd_tree_ctrl: randomized self-checking bench for kd_tree_ctrl with a behavioural root-node stub
`timescale 1ns/1ps
module tb_kd_tree_ctrl;
    import kd_tree_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    kd_tree_ctrl_if bus ();

`ifdef KD_TREE_CTRL_TIMEOUT_EN
    logic error;
    kd_tree_ctrl #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus), .error(error));
`else
    kd_tree_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Root-node stub configuration and observation state.
    int          rst_target = 3;
    int          fill_target = 7;
    int          sort_lat = 3;
    int          pt_lat = 2;
    bit          sort_answer = 1'b1;
    cmd_t        inject = CMD_NOP;
    int          rst_cnt = 0;
    int          rst_seen = 0;
    int          sort_cnt = 0;
    bit          sorting = 1'b0;
    int          pt_cnt = 0;
    int          n_tree = 0;
    logic [23:0] tree_c[8];
    logic [23:0] fill_hi[8];
    int          n_sent = 0;
    logic [23:0] sent_c[8];

    // Nearest center by squared Euclidean distance; first one wins ties.
    function automatic logic [23:0] nearest(input bit from_tree, input logic [23:0] p);
        int n, d, a, best_d;
        logic [23:0] c, best;
        n = from_tree ? n_tree : n_sent;
        best = '0;
        best_d = 0;
        for (int i = 0; i < n; i++) begin
            c = from_tree ? tree_c[i] : sent_c[i];
            d = 0;
            for (int k = 0; k < 3; k++) begin
                a = int'(p[8*k +: 8]) - int'(c[8*k +: 8]);
                d += a * a;
            end
            if (i == 0 || d < best_d) begin
                best_d = d;
                best = c;
            end
        end
        return best;
    endfunction

    // The stub reacts 1 ns after each edge to the command the controller now drives.
    always @(posedge clk) begin
        cmd_t fb_cmd;
        logic [DATA_W-1:0] fb_data;
        #1;
        fb_cmd = CMD_NOP;
        fb_data = '0;
        if (bus.cmd_to_root != CMD_RST) rst_cnt = 0;
        if (bus.cmd_to_root != CMD_POINT_IN) pt_cnt = 0;
        case (bus.cmd_to_root)
            CMD_RST: begin
                rst_cnt++;
                rst_seen++;
                n_tree = 0;
                if (rst_cnt >= rst_target) fb_cmd = CMD_RST_DONE;
            end
            CMD_CENTER_FILL: begin
                if (n_tree < 8) begin
                    tree_c[n_tree] = bus.data_to_root[23:0];
                    fill_hi[n_tree] = bus.data_to_root[47:24];
                end
                n_tree++;
                if (n_tree >= fill_target) fb_cmd = CMD_CENTER_FILL_DONE;
            end
            CMD_START_SORTING: begin
                sorting = 1'b1;
                sort_cnt = 0;
            end
            CMD_POINT_IN: begin
                pt_cnt++;
                if (pt_cnt >= pt_lat) begin
                    fb_cmd = CMD_RETURN_BEST;
                    fb_data = {24'($urandom), nearest(1'b1, bus.data_to_root[23:0])};
                end
            end
            default: if (sorting) begin
                sort_cnt++;
                if (sort_cnt >= sort_lat && sort_answer) begin
                    fb_cmd = CMD_SORT_DONE;
                    sorting = 1'b0;
                end
            end
        endcase
        if (inject != CMD_NOP) fb_cmd = inject;
        bus.cmd_from_root = fb_cmd;
        bus.data_from_root = fb_data;
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic open_session(input int rt);
        int n;
        rst_target = rt;
        rst_seen = 0;
        sorting = 1'b0;
        inject = CMD_NOP;
        sort_answer = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (n = 0; n < 50 && !bus.center_ready; n++) tick();
        checks++;
        if (rst_seen !== rt || !bus.center_ready) begin
            errors++;
            $display("FAIL rst_cycles: got %0d rst cycles ready=%b, expected %0d then FILL", rst_seen, bus.center_ready, rt);
        end
    endtask

    task automatic fill_centers(input int target);
        logic [23:0] cand[8];
        int idx;
        bit acc, seen_sort;
        fill_target = target;
        n_sent = 0;
        for (int i = 0; i < 8; i++) cand[i] = (i == 0) ? 24'h0A000A : 24'($urandom);
        idx = 0;
        seen_sort = 1'b0;
        for (int c = 0; c < 200 && !seen_sort; c++) begin
            bus.center_valid = ($urandom_range(0, 2) != 0) || idx >= target;
            bus.center_data = cand[idx];
            acc = bus.center_valid && bus.center_ready;
            tick();
            if (acc && n_sent < 8) begin
                sent_c[n_sent] = cand[idx];
                n_sent++;
                if (idx < 7) idx++;
            end
            seen_sort = bus.cmd_to_root == CMD_START_SORTING;
        end
        bus.center_valid = 1'b0;
        checks++;
        if (!seen_sort || n_sent !== target) begin
            errors++;
            $display("FAIL fill_count: accepted %0d sort_seen=%b, expected %0d accepted then sort", n_sent, seen_sort, target);
        end
        for (int i = 0; i < target && i < n_sent; i++) begin
            checks++;
            if (tree_c[i] !== sent_c[i] || fill_hi[i] !== 24'h0) begin
                errors++;
                $display("FAIL fill_data[%0d]: got %h_%h, expected 000000_%h", i, fill_hi[i], tree_c[i], sent_c[i]);
            end
        end
        checks++;
        if (bus.data_to_root !== '0) begin
            errors++;
            $display("FAIL sort_data: got %h, expected 0", bus.data_to_root);
        end
        tick();
        checks++;
        if (bus.cmd_to_root !== CMD_NOP || !bus.busy) begin
            errors++;
            $display("FAIL sort_one_cycle: cmd %h busy %b, expected cmd 00 busy 1", bus.cmd_to_root, bus.busy);
        end
    endtask

    task automatic query(input logic [23:0] p, input bit last, input int hold);
        logic [23:0] exp;
        bit acc;
        int n;
        exp = nearest(1'b0, p);
        bus.pix_data = p;
        bus.pix_last = last;
        bus.pix_valid = 1'b1;
        acc = 1'b0;
        for (n = 0; n < 50 && !acc; n++) begin
            acc = bus.pix_ready;
            tick();
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL pix_accept: pix_ready stayed 0, expected 1");
        end
        bus.pix_data = ~p;
        bus.pix_last = 1'b0;
        for (n = 0; n < 50 && !bus.res_valid; n++) begin
            checks++;
            if (bus.cmd_to_root !== CMD_POINT_IN || bus.data_to_root !== {24'h0, p} || bus.pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL point_in: cmd %h data %h ready %b, expected 16 %h 0", bus.cmd_to_root, bus.data_to_root, bus.pix_ready, {24'h0, p});
            end
            tick();
        end
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_best !== exp || bus.res_pix !== p) begin
            errors++;
            $display("FAIL result: valid %b best %h pix %h, expected 1 %h %h", bus.res_valid, bus.res_best, bus.res_pix, exp, p);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_best !== exp || bus.res_pix !== p || bus.pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL res_hold: valid %b best %h pix %h pix_ready %b, expected 1 %h %h 0", bus.res_valid, bus.res_best, bus.res_pix, bus.pix_ready, exp, p);
            end
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        if (last) bus.pix_valid = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.done !== last || bus.pix_ready !== !last) begin
            errors++;
            $display("FAIL res_handshake: valid %b done %b pix_ready %b, expected 0 %b %b", bus.res_valid, bus.done, bus.pix_ready, last, !last);
        end
        if (last) begin
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done %b busy %b, expected 0 0", bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.center_valid = 1'b0;
        bus.center_data = '0;
        bus.pix_valid = 1'b0;
        bus.pix_data = '0;
        bus.pix_last = 1'b0;
        bus.res_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.cmd_to_root !== CMD_NOP || bus.data_to_root !== '0 || bus.center_ready !== 1'b0 || bus.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_root: cmd %h data %h cready %b pready %b, expected 00 0 0 0", bus.cmd_to_root, bus.data_to_root, bus.center_ready, bus.pix_ready);
        end
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_best !== '0 || bus.res_pix !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: rv %b best %h pix %h busy %b done %b, expected all 0", bus.res_valid, bus.res_best, bus.res_pix, bus.busy, bus.done);
        end
`ifdef KD_TREE_CTRL_TIMEOUT_EN
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %b, expected 0", error);
        end
`endif
        reset = 1'b0;
        inject = CMD_RST_DONE;
        tick();
        inject = CMD_SORT_DONE;
        tick();
        inject = CMD_RETURN_BEST;
        tick();
        inject = CMD_NOP;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_to_root !== CMD_NOP || bus.res_valid !== 1'b0 || bus.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: busy %b cmd %h rv %b pready %b, expected 0 00 0 0", bus.busy, bus.cmd_to_root, bus.res_valid, bus.pix_ready);
        end
    endtask

    task automatic test_single_pixel();
        sort_lat = 3;
        pt_lat = 2;
        open_session(3);
        fill_centers(7);
        query(24'h0A000A, 1'b1, 5);
    endtask

    task automatic test_back_to_back();
        logic [23:0] px[3];
        int rt;
        rt = $urandom_range(1, 6);
        sort_lat = $urandom_range(1, 5);
        open_session(rt);
        fill_centers($urandom_range(2, 7));
        for (int i = 0; i < 3; i++) px[i] = 24'($urandom);
        for (int i = 0; i < 3; i++) begin
            pt_lat = $urandom_range(1, 4);
            bus.start = (i == 1);
            query(px[i], i == 2, $urandom_range(0, 2));
            bus.start = 1'b0;
        end
        checks++;
        if (rst_seen !== rt) begin
            errors++;
            $display("FAIL start_ignored: rst cycles %0d, expected %0d", rst_seen, rt);
        end
    endtask

    task automatic test_midsession_reset();
        rst_target = 100;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.cmd_to_root !== CMD_RST) begin
            errors++;
            $display("FAIL rst_drive: cmd %h, expected 1f", bus.cmd_to_root);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_to_root !== CMD_NOP || bus.data_to_root !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy %b cmd %h data %h, expected 0 00 0", bus.busy, bus.cmd_to_root, bus.data_to_root);
        end
        tick();
        sort_lat = 2;
        pt_lat = 1;
        open_session(2);
        fill_centers(3);
        query(24'($urandom), 1'b1, 1);
    endtask

`ifdef KD_TREE_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        open_session(3);
        sort_answer = 1'b0;
        fill_centers(4);
        n = 1;
        while (n < 40 && error !== 1'b1) begin
            tick();
            n++;
        end
        checks++;
        if (n - 1 !== 16 || bus.done !== 1'b1 || bus.cmd_to_root !== CMD_NOP) begin
            errors++;
            $display("FAIL timeout: %0d wait cycles done %b cmd %h, expected 16 1 00", n - 1, bus.done, bus.cmd_to_root);
        end
        tick();
        checks++;
        if (error !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL error_sticky: error %b done %b busy %b, expected 1 0 0", error, bus.done, bus.busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sort_answer = 1'b1;
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: got %b, expected 0", error);
        end
    endtask
`endif

    initial begin
        bus.cmd_from_root = CMD_NOP;
        bus.data_from_root = '0;
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_back_to_back();
        test_midsession_reset();
`ifdef KD_TREE_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "bench did not finish");
    end
endmodule
